radio_ctrl_axil_regs: RTL and testbench

AXI4-Lite responder for the radio peripheral at base 0x43C0_0000. It terminates the write and read bursts issued by the processor system's AXI master. It holds the surrogate-ADC phase increment, the tuner phase increment and the DDS reset control, and it exposes a free-running clock counter. Register outputs drive the DDS/mixer datapath directly in the clk125 domain.

---
 rtl/radio_ctrl_axil_regs_if.sv | 38 +++
 rtl/radio_ctrl_axil_regs.sv | 175 +++++++++++++++++
 tb/tb_radio_ctrl_axil_regs.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/radio_ctrl_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS master and the radio register block.
interface radio_ctrl_axil_regs_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/radio_ctrl_axil_regs.sv
// AXI4-Lite register block for the radio peripheral: two phase increments,
// the DDS reset control and a free-running clock counter.
module radio_ctrl_axil_regs #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk125,
  input  logic                  resetn,
  radio_ctrl_axil_regs_if.slave s_axi,
  output logic [31:0]           adc_pinc,
  output logic [31:0]           tune_pinc,
  output logic                  dds_rst
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_ADC  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_TUNE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CNT  = IDX_W'(3);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic             active_q, active_d;
  logic             aw_held_q, aw_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             w_held_q, w_held_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      adc_q, adc_d;
  logic [31:0]      tune_q, tune_d;
  logic             ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_mux;
  logic             unused_addr_bits;

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // The low address bits select a byte within a word and are not decoded.
  assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Handshakes gate on active_q so the bus stays silent until the first edge after reset.
  assign s_axi.awready = active_q && !aw_held_q && !bvalid_q;
  assign s_axi.wready  = active_q && !w_held_q && !bvalid_q;
  assign s_axi.arready = active_q && !rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid && s_axi.wready;
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign commit = aw_held_q && w_held_q;
  assign ar_idx = s_axi.araddr[ADDR_W-1:2];

  assign adc_pinc  = adc_q;
  assign tune_pinc = tune_q;
  assign dds_rst   = ctrl_q;

  // Read mux over current register values, so a same-edge write is not seen.
  always_comb begin
    rd_mux = 32'h0;
    if (ar_idx == IDX_ADC)       rd_mux = adc_q;
    else if (ar_idx == IDX_TUNE) rd_mux = tune_q;
    else if (ar_idx == IDX_CTRL) rd_mux = {31'h0, ctrl_q};
    else if (ar_idx == IDX_CNT)  rd_mux = cnt_q;
  end

  // Next-state: latch AW/W independently, commit once both are held, run the read channel.
  always_comb begin
    active_d  = 1'b1;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    adc_d     = adc_q;
    tune_d    = tune_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q + 1'b1;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[ADDR_W-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      if (aw_idx_q == IDX_ADC) begin
        adc_d = merge_bytes(adc_q, wdata_q, wstrb_q);
      end else if (aw_idx_q == IDX_TUNE) begin
        tune_d = merge_bytes(tune_q, wdata_q, wstrb_q);
      end else if (aw_idx_q == IDX_CTRL) begin
        if (wstrb_q[0]) ctrl_d = wdata_q[0];
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset aborts any transaction in flight without a response.
  always_ff @(posedge clk125 or negedge resetn) begin
    if (!resetn) begin
      active_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      adc_q     <= 32'h0;
      tune_q    <= 32'h0;
      ctrl_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      active_q  <= active_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      adc_q     <= adc_d;
      tune_q    <= tune_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_radio_ctrl_axil_regs.sv
// Self-checking bench for the radio AXI4-Lite register block.
module tb_radio_ctrl_axil_regs;

  logic        clk125 = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] adc_pinc;
  logic [31:0] tune_pinc;
  logic        dds_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  logic [31:0] m_adc  = 32'h0;
  logic [31:0] m_tune = 32'h0;
  logic        m_ctrl = 1'b0;

  radio_ctrl_axil_regs_if #(.ADDR_W(4)) bus ();

  radio_ctrl_axil_regs #(.ADDR_W(4), .CNT_W(32)) dut (
    .clk125   (clk125),
    .resetn   (resetn),
    .s_axi    (bus),
    .adc_pinc (adc_pinc),
    .tune_pinc(tune_pinc),
    .dds_rst  (dds_rst)
  );

  // 125 MHz clock
  always #4 clk125 = ~clk125;

  // Bench-side edge count, used to reason about elapsed cycles between reads
  always @(posedge clk125) edge_cnt <= edge_cnt + 1;

  // Hard stop in case the run wedges
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: register map semantics with byte enables
  task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    resp = 2'b00;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (addr[3:2] == 2'd0) m_adc[8*b +: 8]  = data[8*b +: 8];
        if (addr[3:2] == 2'd1) m_tune[8*b +: 8] = data[8*b +: 8];
      end
    end
    if (addr[3:2] == 2'd2 && strb[0]) m_ctrl = data[0];
    if (addr[3:2] == 2'd3) resp = 2'b10;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr[3:2])
      2'd0:    return m_adc;
      2'd1:    return m_tune;
      2'd2:    return {31'h0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus_idle();
    bus.awaddr = 4'h0; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = 4'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  // Runs handshakes for already-driven AW/W valids, then takes the response (bready high)
  task automatic finish_write(output logic [1:0] resp, output logic ok);
    int n;
    logic aw_go, w_go;
    n = 0;
    bus.bready = 1'b1;
    while ((bus.awvalid || bus.wvalid) && n < 100) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      @(negedge clk125);
      n++;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
    end
    while (!bus.bvalid && n < 100) begin
      @(negedge clk125);
      n++;
    end
    ok   = bus.bvalid;
    resp = bus.bresp;
    @(negedge clk125);
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output logic ok);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    finish_write(resp, ok);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic ok, output int hs_edge);
    int n;
    logic go;
    n = 0;
    hs_edge = -1;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (bus.arvalid && n < 100) begin
      go = bus.arready;
      if (go) hs_edge = edge_cnt + 1;
      @(negedge clk125);
      n++;
      if (go) bus.arvalid = 1'b0;
    end
    while (!bus.rvalid && n < 100) begin
      @(negedge clk125);
      n++;
    end
    ok   = bus.rvalid && (bus.rresp === 2'b00);
    data = bus.rdata;
    @(negedge clk125);
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    bus_idle();
    resetn = 1'b0;
    repeat (3) @(negedge clk125);
    n_checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_handshake: got %b expected 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    n_checks++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_resp_data: got bresp=%b rresp=%b rdata=%h expected zeros",
               bus.bresp, bus.rresp, bus.rdata);
    end
    n_checks++;
    if ({adc_pinc, tune_pinc, dds_rst} !== 65'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: got adc=%h tune=%h dds=%b expected zeros",
               adc_pinc, tune_pinc, dds_rst);
    end
    resetn = 1'b1;
    @(negedge clk125);
    n_checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b expected 111",
               {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_basic_write();
    logic [1:0] resp, exp;
    logic ok;
    logic [31:0] rd;
    int e;
    axi_write(4'h4, 32'd1000000, 4'hF, resp, ok);
    model_write(4'h4, 32'd1000000, 4'hF, exp);
    n_checks++;
    if ({ok, resp} !== 3'b100 || tune_pinc !== 32'h000F_4240) begin
      n_fail++;
      $display("[TB] FAIL basic_tune: got ok=%b resp=%b tune=%h expected 1/00/000f4240",
               ok, resp, tune_pinc);
    end
    axi_write(4'h0, 32'd1001000, 4'hF, resp, ok);
    model_write(4'h0, 32'd1001000, 4'hF, exp);
    n_checks++;
    if ({ok, resp} !== 3'b100 || adc_pinc !== 32'h000F_4628) begin
      n_fail++;
      $display("[TB] FAIL basic_adc: got ok=%b resp=%b adc=%h expected 1/00/000f4628",
               ok, resp, adc_pinc);
    end
    axi_read(4'h4, rd, ok, e);
    n_checks++;
    if (!ok || rd !== 32'h000F_4240) begin
      n_fail++;
      $display("[TB] FAIL basic_read_tune: got ok=%b data=%h expected 000f4240", ok, rd);
    end
    axi_read(4'h0, rd, ok, e);
    n_checks++;
    if (!ok || rd !== 32'h000F_4628) begin
      n_fail++;
      $display("[TB] FAIL basic_read_adc: got ok=%b data=%h expected 000f4628", ok, rd);
    end
  endtask

  task automatic test_split_w_first();
    logic [1:0] resp, exp;
    logic ok;
    axi_write(4'h0, 32'h0, 4'hF, resp, ok);
    model_write(4'h0, 32'h0, 4'hF, exp);
    bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'h5; bus.wvalid = 1'b1; bus.bready = 1'b1;
    @(negedge clk125);
    bus.wvalid = 1'b0;
    n_checks++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL split_w_held: got wready=%b bvalid=%b expected 0/0", bus.wready, bus.bvalid);
    end
    repeat (2) @(negedge clk125);
    n_checks++;
    if (bus.bvalid !== 1'b0 || adc_pinc !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL split_no_commit: got bvalid=%b adc=%h expected 0/00000000", bus.bvalid, adc_pinc);
    end
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    @(negedge clk125);
    bus.awvalid = 1'b0;
    n_checks++;
    if (bus.bvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL split_bvalid_early: got %b expected 0", bus.bvalid);
    end
    @(negedge clk125);
    model_write(4'h0, 32'hDEAD_BEEF, 4'h5, exp);
    n_checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== exp || adc_pinc !== m_adc || m_adc !== 32'h00AD_00EF) begin
      n_fail++;
      $display("[TB] FAIL split_commit: got bvalid=%b bresp=%b adc=%h expected 1/%b/%h",
               bus.bvalid, bus.bresp, adc_pinc, exp, m_adc);
    end
    @(negedge clk125);
    bus.bready = 1'b0;
  endtask

  task automatic test_bready_hold();
    logic [1:0] resp, exp, held;
    logic ok;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    bus.bready = 1'b0;
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    bus.wdata = d1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk125);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk125);
    model_write(4'h4, d1, 4'hF, exp);
    held = bus.bresp;
    n_checks++;
    if (bus.bvalid !== 1'b1 || held !== exp || tune_pinc !== m_tune) begin
      n_fail++;
      $display("[TB] FAIL hold_first: got bvalid=%b bresp=%b tune=%h expected 1/%b/%h",
               bus.bvalid, held, tune_pinc, exp, m_tune);
    end
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    bus.wdata = d2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk125);
      n_checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== held || bus.awready !== 1'b0 ||
          bus.wready !== 1'b0 || adc_pinc !== m_adc) begin
        n_fail++;
        $display("[TB] FAIL hold_cycle%0d: got bvalid=%b bresp=%b awready=%b wready=%b adc=%h expected 1/%b/0/0/%h",
                 i, bus.bvalid, bus.bresp, bus.awready, bus.wready, adc_pinc, held, m_adc);
      end
    end
    bus.bready = 1'b1;
    @(negedge clk125);
    n_checks++;
    if (bus.bvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL hold_release: got bvalid=%b expected 0", bus.bvalid);
    end
    finish_write(resp, ok);
    model_write(4'h0, d2, 4'hF, exp);
    n_checks++;
    if ({ok, resp} !== {1'b1, exp} || adc_pinc !== m_adc) begin
      n_fail++;
      $display("[TB] FAIL hold_second: got ok=%b resp=%b adc=%h expected 1/%b/%h",
               ok, resp, adc_pinc, exp, m_adc);
    end
  endtask

  task automatic test_clk_cnt();
    logic [31:0] v1, v2, v3;
    logic ok1, ok2, ok3, okw;
    logic [1:0] resp;
    int e1, e2, e3;
    axi_read(4'hC, v1, ok1, e1);
    while (edge_cnt < e1 + 49) @(negedge clk125);
    axi_read(4'hC, v2, ok2, e2);
    n_checks++;
    if (!ok1 || !ok2 || (v2 - v1) !== 32'(e2 - e1)) begin
      n_fail++;
      $display("[TB] FAIL cnt_delta: got %0d expected %0d", v2 - v1, e2 - e1);
    end
    axi_write(4'hC, 32'h1234, 4'hF, resp, okw);
    n_checks++;
    if ({okw, resp} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL cnt_write_slverr: got ok=%b resp=%b expected 1/10", okw, resp);
    end
    axi_read(4'hC, v3, ok3, e3);
    n_checks++;
    if (!ok3 || (v3 - v1) !== 32'(e3 - e1)) begin
      n_fail++;
      $display("[TB] FAIL cnt_after_write: got delta %0d expected %0d", v3 - v1, e3 - e1);
    end
  endtask

  task automatic test_ctrl();
    logic [1:0] resp, exp;
    logic ok;
    logic [31:0] rd;
    int e;
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, resp, ok);
    model_write(4'h8, 32'hFFFF_FFFF, 4'hF, exp);
    n_checks++;
    if ({ok, resp} !== 3'b100 || dds_rst !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ctrl_set: got ok=%b resp=%b dds=%b expected 1/00/1", ok, resp, dds_rst);
    end
    axi_read(4'h8, rd, ok, e);
    n_checks++;
    if (!ok || rd !== 32'h1) begin
      n_fail++;
      $display("[TB] FAIL ctrl_read: got %h expected 00000001", rd);
    end
    axi_write(4'h8, 32'h0, 4'hF, resp, ok);
    model_write(4'h8, 32'h0, 4'hF, exp);
    n_checks++;
    if ({ok, resp} !== 3'b100 || dds_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ctrl_clear: got ok=%b resp=%b dds=%b expected 1/00/0", ok, resp, dds_rst);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, exp;
    logic ok;
    logic [31:0] d, rd;
    logic [3:0] a, s;
    int e;
    for (int i = 0; i < 40; i++) begin
      a = {2'($urandom_range(0, 3)), 2'($urandom)};
      d = $urandom;
      s = 4'($urandom);
      axi_write(a, d, s, resp, ok);
      model_write(a, d, s, exp);
      n_checks++;
      if ({ok, resp} !== {1'b1, exp} || adc_pinc !== m_adc || tune_pinc !== m_tune || dds_rst !== m_ctrl) begin
        n_fail++;
        $display("[TB] FAIL rand_write%0d: addr=%h got resp=%b adc=%h tune=%h dds=%b expected %b/%h/%h/%b",
                 i, a, resp, adc_pinc, tune_pinc, dds_rst, exp, m_adc, m_tune, m_ctrl);
      end
      a = {2'($urandom_range(0, 2)), 2'($urandom)};
      axi_read(a, rd, ok, e);
      n_checks++;
      if (!ok || rd !== model_read(a)) begin
        n_fail++;
        $display("[TB] FAIL rand_read%0d: addr=%h got %h expected %h", i, a, rd, model_read(a));
      end
    end
  endtask

  task automatic test_same_edge_rw();
    logic [1:0] exp;
    logic [31:0] old_val, d;
    old_val = m_adc;
    d = ~m_adc;
    n_checks++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL same_edge_idle: got awready=%b arready=%b expected 1/1", bus.awready, bus.arready);
    end
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    @(negedge clk125);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 4'h0; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk125);
    bus.arvalid = 1'b0;
    model_write(4'h0, d, 4'hF, exp);
    n_checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old_val || bus.bvalid !== 1'b1 || adc_pinc !== m_adc) begin
      n_fail++;
      $display("[TB] FAIL same_edge_rw: got rvalid=%b rdata=%h bvalid=%b adc=%h expected 1/%h/1/%h",
               bus.rvalid, bus.rdata, bus.bvalid, adc_pinc, old_val, m_adc);
    end
    bus.rready = 1'b1;
    @(negedge clk125);
    bus.rready = 1'b0; bus.bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, exp;
    logic ok;
    logic [31:0] d, rd;
    int e;
    axi_write(4'h8, 32'h1, 4'h1, resp, ok);
    model_write(4'h8, 32'h1, 4'h1, exp);
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    bus.araddr = 4'h0; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk125);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    n_checks++;
    if (bus.awready !== 1'b0 || bus.rvalid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_setup: got awready=%b rvalid=%b expected 0/1", bus.awready, bus.rvalid);
    end
    #2;
    resetn = 1'b0;
    #1;
    m_adc = 32'h0; m_tune = 32'h0; m_ctrl = 1'b0;
    n_checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b0 || bus.rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_bus: got valids/readies=%b rdata=%h expected 00000/00000000",
               {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, bus.rdata);
    end
    n_checks++;
    if (adc_pinc !== m_adc || tune_pinc !== m_tune || dds_rst !== m_ctrl) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_regs: got adc=%h tune=%h dds=%b expected zeros", adc_pinc, tune_pinc, dds_rst);
    end
    @(negedge clk125);
    resetn = 1'b1;
    @(negedge clk125);
    d = $urandom;
    axi_write(4'h4, d, 4'hF, resp, ok);
    model_write(4'h4, d, 4'hF, exp);
    n_checks++;
    if ({ok, resp} !== {1'b1, exp} || tune_pinc !== m_tune) begin
      n_fail++;
      $display("[TB] FAIL mid_post_write: got ok=%b resp=%b tune=%h expected 1/%b/%h",
               ok, resp, tune_pinc, exp, m_tune);
    end
    axi_read(4'h4, rd, ok, e);
    n_checks++;
    if (!ok || rd !== m_tune) begin
      n_fail++;
      $display("[TB] FAIL mid_post_read: got %h expected %h", rd, m_tune);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_basic_write();
    test_split_w_first();
    test_bready_hold();
    test_clk_cnt();
    test_ctrl();
    test_random();
    test_same_edge_rw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
